ysyx_22041461_dcache_nway: RTL

Parametrised N-way set-associative, write-through, no-write-allocate data cache between the LSU and the memory bus. It replaces the fixed 2-way, single-word, DPI-backed cache with multi-word lines, a ready/valid request/response interface on both sides, and a beat-based refill FSM. It adds per-set round-robin replacement, an uncached bypass window and a whole-cache invalidate.

---
 rtl/ysyx_22041461_dcache_nway_pkg.sv | 25 ++
 rtl/ysyx_22041461_dcache_way.sv | 57 +++++
 rtl/ysyx_22041461_dcache_nway.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041461_dcache_nway_pkg.sv
// Shared definitions for the N-way data cache: parameter defaults, FSM states and
// a helper for deriving address-field widths.
package ysyx_22041461_dcache_nway_pkg;

    localparam int unsigned DEF_WAYS       = 2;
    localparam int unsigned DEF_SETS       = 64;
    localparam int unsigned DEF_LINE_BYTES = 16;
    localparam logic [63:0] DEF_MEM_LO     = 64'h0000_0000_8000_0000;
    localparam logic [63:0] DEF_MEM_HI     = 64'h0000_0000_8fff_ffff;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StRefill,
        StMemwr,
        StUncached,
        StResp
    } state_e;

    // Field width that never collapses to zero bits (e.g. a 1-way or 1-beat config).
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22041461_dcache_way.sv
// One cache way: byte-writable data array with asynchronous read, plus tag and
// valid arrays. Valid bits reset asynchronously and clear on a whole-cache flush.
module ysyx_22041461_dcache_way #(
    parameter int unsigned SETS  = 64,
    parameter int unsigned BEATS = 2,
    parameter int unsigned TAGW  = 54,
    parameter int unsigned IDXW  = 6,
    parameter int unsigned WSW   = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic [IDXW-1:0] i_index,
    input  logic [WSW-1:0]  i_rd_word,
    output logic [63:0]     o_rdata,
    output logic            o_valid,
    output logic [TAGW-1:0] o_tag,
    input  logic            i_wr_en,
    input  logic [WSW-1:0]  i_wr_word,
    input  logic [63:0]     i_wr_data,
    input  logic [7:0]      i_wr_mask,
    input  logic            i_fill,
    input  logic [TAGW-1:0] i_fill_tag
);

    logic [63:0]     r_data [SETS][BEATS];
    logic [TAGW-1:0] r_tag  [SETS];
    logic [SETS-1:0] r_valid;

    assign o_rdata = r_data[i_index][i_rd_word];
    assign o_valid = r_valid[i_index];
    assign o_tag   = r_tag[i_index];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
        end else if (i_clear) begin
            r_valid <= '0;
        end else if (i_fill) begin
            r_valid[i_index] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_fill) begin
            r_tag[i_index] <= i_fill_tag;
        end
        if (i_wr_en) begin
            for (int b = 0; b < 8; b++) begin
                if (i_wr_mask[b]) begin
                    r_data[i_index][i_wr_word][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/ysyx_22041461_dcache_nway.sv
// Write-through, no-write-allocate N-way data cache with beat-based refill,
// per-set round-robin replacement, an uncached window and whole-cache flush.
module ysyx_22041461_dcache_nway
    import ysyx_22041461_dcache_nway_pkg::*;
#(
    parameter int unsigned WAYS       = DEF_WAYS,
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned LINE_BYTES = DEF_LINE_BYTES,
    parameter logic [63:0] MEM_LO     = DEF_MEM_LO,
    parameter logic [63:0] MEM_HI     = DEF_MEM_HI
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [63:0] i_req_addr,
    input  logic        i_req_wen,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wmask,
    input  logic        i_flush,
    output logic        o_resp_valid,
    output logic [63:0] o_resp_rdata,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic [63:0] o_mem_req_addr,
    output logic        o_mem_req_wen,
    output logic [63:0] o_mem_req_wdata,
    output logic [7:0]  o_mem_req_wmask,
    input  logic        i_mem_resp_valid,
    input  logic [63:0] i_mem_resp_rdata
);

    localparam int unsigned BEATS = LINE_BYTES / 8;
    localparam int unsigned OFFW  = $clog2(LINE_BYTES);
    localparam int unsigned IDXW  = $clog2(SETS);
    localparam int unsigned TAGW  = 64 - OFFW - IDXW;
    localparam int unsigned WSW   = clog2_min1(BEATS);
    localparam int unsigned WYW   = clog2_min1(WAYS);

    state_e          r_state, w_state_d;
    logic [63:0]     r_addr, r_wdata, r_rdata;
    logic            r_wen, r_wait, r_victim_rr;
    logic [7:0]      r_wmask;
    logic [WYW-1:0]  r_victim;
    logic [WSW-1:0]  r_beat;
    logic [WYW-1:0]  r_rr [SETS];

    logic [IDXW-1:0] w_index;
    logic [TAGW-1:0] w_tag;
    logic [WSW-1:0]  w_word;
    logic            w_cacheable, w_last_beat, w_mem_ack;
    logic [63:0]     w_way_rdata [WAYS];
    logic [TAGW-1:0] w_way_tag   [WAYS];
    logic [WAYS-1:0] w_way_valid, w_wr_en, w_fill;
    logic [WSW-1:0]  w_wr_word;
    logic [63:0]     w_wr_data, w_hit_data;
    logic [7:0]      w_wr_mask;
    logic            w_clear, w_hit_any, w_inv_any;
    logic [WYW-1:0]  w_hit_way, w_inv_way, w_rr_next;

    assign w_index     = IDXW'(r_addr >> OFFW);
    assign w_tag       = TAGW'(r_addr >> (OFFW + IDXW));
    assign w_word      = WSW'((r_addr >> 3) & 64'(BEATS - 1));
    assign w_cacheable = (r_addr >= MEM_LO) && (r_addr <= MEM_HI);
    assign w_last_beat = (r_beat == WSW'(BEATS - 1));
    assign w_mem_ack   = r_wait && i_mem_resp_valid;
    assign w_rr_next   = (r_rr[w_index] == WYW'(WAYS - 1)) ? '0 : r_rr[w_index] + 1'b1;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        ysyx_22041461_dcache_way #(
            .SETS (SETS),
            .BEATS(BEATS),
            .TAGW (TAGW),
            .IDXW (IDXW),
            .WSW  (WSW)
        ) u_way (
            .i_clk     (i_clk),
            .i_rst_n   (i_rst_n),
            .i_clear   (w_clear),
            .i_index   (w_index),
            .i_rd_word (w_word),
            .o_rdata   (w_way_rdata[g]),
            .o_valid   (w_way_valid[g]),
            .o_tag     (w_way_tag[g]),
            .i_wr_en   (w_wr_en[g]),
            .i_wr_word (w_wr_word),
            .i_wr_data (w_wr_data),
            .i_wr_mask (w_wr_mask),
            .i_fill    (w_fill[g]),
            .i_fill_tag(w_tag)
        );
    end

    // Downward scan so the lowest-index match / invalid way wins.
    always_comb begin
        w_hit_any  = 1'b0;
        w_hit_way  = '0;
        w_hit_data = '0;
        w_inv_any  = 1'b0;
        w_inv_way  = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_way_valid[w] && (w_way_tag[w] == w_tag)) begin
                w_hit_any  = 1'b1;
                w_hit_way  = WYW'(w);
                w_hit_data = w_way_rdata[w];
            end
            if (!w_way_valid[w]) begin
                w_inv_any = 1'b1;
                w_inv_way = WYW'(w);
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_clear   = 1'b0;
        w_wr_en   = '0;
        w_fill    = '0;
        w_wr_word = w_word;
        w_wr_data = r_wdata;
        w_wr_mask = r_wmask;
        unique case (r_state)
            StIdle: begin
                if (i_flush) begin
                    w_clear = 1'b1;
                end else if (i_req_valid) begin
                    w_state_d = StLookup;
                end
            end
            StLookup: begin
                if (r_wen && (r_wmask == 8'h00)) begin
                    w_state_d = StResp;
                end else if (!w_cacheable) begin
                    w_state_d = StUncached;
                end else if (r_wen) begin
                    if (w_hit_any) begin
                        w_wr_en[w_hit_way] = 1'b1;
                    end
                    w_state_d = StMemwr;
                end else if (w_hit_any) begin
                    w_state_d = StResp;
                end else begin
                    w_state_d = StRefill;
                end
            end
            StRefill: begin
                if (w_mem_ack) begin
                    w_wr_en[r_victim] = 1'b1;
                    w_wr_word         = r_beat;
                    w_wr_data         = i_mem_resp_rdata;
                    w_wr_mask         = 8'hff;
                    if (w_last_beat) begin
                        w_fill[r_victim] = 1'b1;
                        w_state_d        = StResp;
                    end
                end
            end
            StMemwr, StUncached: begin
                if (w_mem_ack) begin
                    w_state_d = StResp;
                end
            end
            StResp:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        o_req_ready     = (r_state == StIdle) && !i_flush;
        o_resp_valid    = (r_state == StResp);
        o_resp_rdata    = o_resp_valid ? r_rdata : '0;
        o_mem_req_valid = ((r_state == StRefill) || (r_state == StMemwr) ||
                           (r_state == StUncached)) && !r_wait;
        o_mem_req_addr  = '0;
        if (o_mem_req_valid) begin
            o_mem_req_addr = (r_state == StRefill)
                ? ((r_addr & ~64'(LINE_BYTES - 1)) | (64'(r_beat) << 3))
                : {r_addr[63:3], 3'b000};
        end
        o_mem_req_wen   = o_mem_req_valid && (r_state != StRefill) && r_wen;
        o_mem_req_wdata = o_mem_req_wen ? r_wdata : '0;
        o_mem_req_wmask = o_mem_req_wen ? r_wmask : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_addr      <= '0;
            r_wen       <= 1'b0;
            r_wdata     <= '0;
            r_wmask     <= '0;
            r_rdata     <= '0;
            r_wait      <= 1'b0;
            r_beat      <= '0;
            r_victim    <= '0;
            r_victim_rr <= 1'b0;
            for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
        end else begin
            r_state <= w_state_d;
            if (o_mem_req_valid && i_mem_req_ready) begin
                r_wait <= 1'b1;
            end
            unique case (r_state)
                StIdle: begin
                    if (i_flush) begin
                        for (int s = 0; s < SETS; s++) r_rr[s] <= '0;
                    end else if (i_req_valid) begin
                        r_addr  <= i_req_addr;
                        r_wen   <= i_req_wen;
                        r_wdata <= i_req_wdata;
                        r_wmask <= i_req_wmask;
                        r_wait  <= 1'b0;
                        r_beat  <= '0;
                    end
                end
                StLookup: begin
                    r_rdata     <= r_wen ? '0 : w_hit_data;
                    r_victim    <= w_inv_any ? w_inv_way : r_rr[w_index];
                    r_victim_rr <= !w_inv_any;
                end
                StRefill: begin
                    if (w_mem_ack) begin
                        r_wait <= 1'b0;
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == w_word) begin
                            r_rdata <= i_mem_resp_rdata;
                        end
                        if (w_last_beat && r_victim_rr) begin
                            r_rr[w_index] <= w_rr_next;
                        end
                    end
                end
                StMemwr, StUncached: begin
                    if (w_mem_ack) begin
                        r_wait  <= 1'b0;
                        r_rdata <= r_wen ? '0 : i_mem_resp_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
